mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: AGE_LIMIT, default 8, the number of pending-debug cycles before a forced debug grant; MAX_BURST, default 4, the maximum consecutive locked debug beats.
REQ-002 SHALL have ports: Clk  in  1  single clock, all state updated on rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL have ports: c_req  in  1 / c_wr  in  1 / c_addr  in  32 / c_wdata  in  32  CPU access request, write flag, address, write data.
REQ-005 SHALL have ports: c_gnt  out  1 / c_rvalid  out  1 / c_rdata  out  32  CPU grant, read-data valid, read data.
REQ-006 SHALL have ports: d_req  in  1 / d_wr  in  1 / d_lock  in  1 / d_addr  in  32 / d_wdata  in  32  debug/DMA request, write flag, burst lock, address, write data.
REQ-007 SHALL have ports: d_gnt  out  1 / d_rvalid  out  1 / d_rdata  out  32  debug grant, read-data valid, read data.
REQ-008 SHALL have ports: mem_addr  out  32 / mem_wr  out  1 / mem_wdata  out  32 / mem_rdata  in  32  single-port memory side (1-cycle synchronous read).

Function
REQ-009 SHALL grant at most one requester per cycle; c_gnt and d_gnt are never both 1.
REQ-010 SHALL drive grants combinationally in the request cycle; the memory samples the access on the next rising edge.
REQ-011 SHALL route the granted port's addr/wr/wdata to mem_*; with no grant, mem_wr=0 and mem_addr/mem_wdata hold their last value.
REQ-012 SHALL require requesters to hold req/addr/wr/wdata stable until they see their grant; one grant = one beat.
REQ-013 SHALL assert <x>_rvalid for exactly one cycle, one cycle after a granted read, with <x>_rdata = mem_rdata; writes produce no rvalid.
REQ-014 SHALL hold c_rdata/d_rdata between valid pulses.
REQ-015 SHALL implement a FSM with states IDLE, CPU, DBG and DBG_LOCK.
REQ-016 SHALL transition IDLE/CPU/DBG to the winner of the current cycle's arbitration, or to IDLE when neither port requests.
REQ-017 SHALL enter DBG_LOCK when the debug port is granted with d_lock=1.
REQ-018 SHALL, in DBG_LOCK, grant only the debug port while d_lock=1 and d_req=1, counting beats.
REQ-019 SHALL exit DBG_LOCK to IDLE after MAX_BURST beats, or when d_lock=0 or d_req=0, whichever comes first.
REQ-020 SHALL, on exit from DBG_LOCK, make the CPU the priority winner for the next cycle if c_req=1.
REQ-021 SHALL use default priority outside lock: CPU over debug (subject to the aging feature).
REQ-022 SHALL use a burst counter of width clog2(MAX_BURST+1) that saturates and never wraps.

Reset
REQ-023 SHALL, while reset=0, set: state IDLE; c_gnt=d_gnt=0; c_rvalid=d_rvalid=0; c_rdata=d_rdata=0; mem_wr=0; mem_addr=mem_wdata=0; burst and age counters 0.
REQ-024 SHALL discard any read issued in the cycle reset asserts; no rvalid follows reset deassertion.
REQ-025 SHALL grant nothing in the first cycle after reset deassertion, then arbitrate normally.

Configuration
REQ-026 SHALL, with macro MEM_ARB_AGING_EN defined, keep an age counter that increments each cycle d_req=1 and d_gnt=0, and clears on d_gnt.
REQ-027 SHALL, with MEM_ARB_AGING_EN defined, give the debug port priority over the CPU for one beat when the age counter reaches AGE_LIMIT; the counter saturates at AGE_LIMIT.
REQ-028 SHALL, without MEM_ARB_AGING_EN, use strict CPU priority, omit the age counter logic, and ignore AGE_LIMIT.

Verification
REQ-029 SHALL cover: c_req=1 read addr 0x10 with mem_rdata=0xDEADBEEF -> c_gnt same cycle; c_rvalid=1 and c_rdata=0xDEADBEEF next cycle for one cycle.
REQ-030 SHALL cover: c_req and d_req both 1 (no lock, age 0) -> c_gnt=1, d_gnt=0; d_gnt=1 in the first cycle c_req=0.
REQ-031 SHALL cover: d_lock=1, d_req held 6 beats, MAX_BURST=4, c_req=1 -> d_gnt exactly 4 consecutive cycles, then c_gnt=1.
REQ-032 SHALL cover (MEM_ARB_AGING_EN, AGE_LIMIT=8): c_req and d_req held continuously -> d_gnt=1 on the 9th cycle for one beat, then c_gnt resumes.
REQ-033 SHALL cover: reset=0 asserted in the cycle after a granted debug read -> d_rvalid stays 0, all outputs zero, state IDLE after release.
REQ-034 SHALL cover: CPU write addr 0x20 data 0x12345678, then debug read 0x20 -> mem_wr=1 one cycle; d_rdata=0x12345678 with d_rvalid.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-port synchronous memory.
// Define MEM_ARB_AGING_EN to let a starved debug port win over the CPU.
module mem_arbiter #(
  parameter int AGE_LIMIT = 8,
  parameter int MAX_BURST = 4
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_wr,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic        d_lock,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    DBG,
    DBG_LOCK
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] burst, burst_n, beat;
  logic          live;
  logic          cpu_first, cpu_first_n;
  logic          d_pri;
  logic          c_pend, d_pend;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   c_rdata_q, d_rdata_q;

`ifdef MEM_ARB_AGING_EN
  localparam int AW = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);
  logic [AW-1:0] age;

  assign d_pri = (age == AW'(AGE_LIMIT)) && !cpu_first;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      age <= '0;
    end else if (d_gnt) begin
      age <= '0;
    end else if (d_req && age != AW'(AGE_LIMIT)) begin
      age <= age + 1'b1;
    end
  end
`else
  assign d_pri = 1'b0;
`endif

  // Beat number a granted locked beat would carry; saturates at MAX_BURST.
  assign beat = (state != DBG_LOCK) ? BW'(1) :
                (burst == BW'(MAX_BURST)) ? burst : burst + 1'b1;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      burst     <= '0;
      live      <= 1'b0;
      cpu_first <= 1'b0;
    end else begin
      state     <= state_n;
      burst     <= burst_n;
      live      <= 1'b1;
      cpu_first <= cpu_first_n;
    end
  end

  always_comb begin
    state_n     = state;
    burst_n     = burst;
    cpu_first_n = 1'b0;
    c_gnt       = 1'b0;
    d_gnt       = 1'b0;
    if (live) begin
      unique case (state)
        DBG_LOCK: begin
          if (d_req && d_lock) begin
            d_gnt   = 1'b1;
            burst_n = beat;
            if (beat == BW'(MAX_BURST)) begin
              state_n     = IDLE;
              cpu_first_n = 1'b1;
            end
          end else begin
            state_n     = IDLE;
            burst_n     = '0;
            cpu_first_n = 1'b1;
          end
        end
        IDLE, CPU, DBG: begin
          burst_n = '0;
          if (d_req && (d_pri || !c_req)) begin
            d_gnt   = 1'b1;
            state_n = DBG;
            if (d_lock) begin
              burst_n = beat;
              if (beat == BW'(MAX_BURST)) begin
                state_n     = IDLE;
                cpu_first_n = 1'b1;
              end else begin
                state_n = DBG_LOCK;
              end
            end
          end else if (c_req) begin
            c_gnt   = 1'b1;
            state_n = CPU;
          end else begin
            state_n = IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wr    = 1'b0;
    if (c_gnt) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_wr    = c_wr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wr    = d_wr;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      c_pend    <= 1'b0;
      d_pend    <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      c_pend  <= c_gnt && !c_wr;
      d_pend  <= d_gnt && !d_wr;
      if (c_pend) c_rdata_q <= mem_rdata;
      if (d_pend) d_rdata_q <= mem_rdata;
    end
  end

  // Read data arrives from memory in the cycle after the grant.
  assign c_rvalid = c_pend;
  assign d_rvalid = d_pend;
  assign c_rdata  = c_pend ? mem_rdata : c_rdata_q;
  assign d_rdata  = d_pend ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cases plus random traffic.
// Honours MEM_ARB_AGING_EN when the design is built with it.
module tb_mem_arbiter;

  localparam int AGE_LIMIT = 8;
  localparam int MAX_BURST = 4;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 0, c_wr = 0;
  logic [31:0] c_addr = 0, c_wdata = 0;
  logic        d_req = 0, d_wr = 0, d_lock = 0;
  logic [31:0] d_addr = 0, d_wdata = 0;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wr;
  logic [31:0] mem_rdata = 0;

  always #5 Clk = ~Clk;

  mem_arbiter #(.AGE_LIMIT(AGE_LIMIT), .MAX_BURST(MAX_BURST)) dut (
    .Clk(Clk), .reset(reset),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_lock(d_lock), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] env_mem [logic [31:0]];

  always @(posedge Clk) begin
    if (mem_wr) env_mem[mem_addr] = mem_wdata;
    mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : 32'h0;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t cq[$];
  exp_t dq[$];

  logic [31:0] model_mem [logic [31:0]];
  int          m_lock_left, m_age;
  logic        m_cpu_first, m_live;
  logic [31:0] m_last_addr, m_last_wdata;
  logic        g_c, g_d, o_cg, o_dg, o_mw;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  // Monitor: every read-data pulse must match the oldest expected read.
  always @(negedge Clk) begin
    if (reset) begin
      if (c_rvalid) begin
        if (cq.size() != 0 && cq[0].due == cyc) begin
          chk("c_rdata", c_rdata, cq[0].data);
          void'(cq.pop_front());
        end else chk("c_rvalid_unexpected", c_rvalid, 0);
      end else if (cq.size() != 0 && cq[0].due <= cyc) begin
        chk("c_rvalid_missing", c_rvalid, 1);
        void'(cq.pop_front());
      end
      if (d_rvalid) begin
        if (dq.size() != 0 && dq[0].due == cyc) begin
          chk("d_rdata", d_rdata, dq[0].data);
          void'(dq.pop_front());
        end else chk("d_rvalid_unexpected", d_rvalid, 0);
      end else if (dq.size() != 0 && dq[0].due <= cyc) begin
        chk("d_rvalid_missing", d_rvalid, 1);
        void'(dq.pop_front());
      end
    end
  end

  // One cycle: predict the winner from the arbitration rules, compare,
  // queue expected reads, then advance to just after the clock edge.
  task automatic step();
    logic cg, dg, cf, dpri, ew;
    logic [31:0] ea, ewd;
    exp_t e;
    @(negedge Clk);
    cg = 0;
    dg = 0;
    dpri = 0;
    cf = m_cpu_first;
    m_cpu_first = 0;
    if (m_live && m_lock_left > 0) begin
      if (d_req && d_lock) begin
        dg = 1;
        m_lock_left--;
        if (m_lock_left == 0) m_cpu_first = 1;
      end else begin
        m_lock_left = 0;
        m_cpu_first = 1;
      end
    end else if (m_live) begin
`ifdef MEM_ARB_AGING_EN
      dpri = (m_age >= AGE_LIMIT) && !cf;
`endif
      if (d_req && (dpri || !c_req)) begin
        dg = 1;
        if (d_lock) begin
          m_lock_left = MAX_BURST - 1;
          if (m_lock_left == 0) m_cpu_first = 1;
        end
      end else if (c_req) cg = 1;
    end
`ifdef MEM_ARB_AGING_EN
    if (dg) m_age = 0;
    else if (d_req && m_age < AGE_LIMIT) m_age++;
`endif
    ew  = (cg && c_wr) || (dg && d_wr);
    ea  = cg ? c_addr : dg ? d_addr : m_last_addr;
    ewd = cg ? c_wdata : dg ? d_wdata : m_last_wdata;
    o_cg = c_gnt;
    o_dg = d_gnt;
    o_mw = mem_wr;
    chk("c_gnt", c_gnt, cg);
    chk("d_gnt", d_gnt, dg);
    chk("mem_wr", mem_wr, ew);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ewd);
    if ((cg || dg) && !ew) begin
      e.due = cyc + 1;
      e.data = mread(ea);
      if (cg) cq.push_back(e);
      else dq.push_back(e);
    end
    if (ew) model_mem[ea] = ewd;
    m_last_addr = ea;
    m_last_wdata = ewd;
    m_live = 1;
    g_c = cg;
    g_d = dg;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    d_req = 0;
    d_lock = 0;
    c_req = 1;
    c_wr = 0;
    c_addr = 32'h44;
    #1;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    cq.delete();
    dq.delete();
    m_lock_left = 0;
    m_age = 0;
    m_cpu_first = 0;
    m_live = 0;
    m_last_addr = 0;
    m_last_wdata = 0;
    repeat (2) @(posedge Clk);
    #1;
    reset = 1;
  endtask

  initial begin
    int n;
    env_mem[32'h10] = 32'hDEADBEEF;
    model_mem[32'h10] = 32'hDEADBEEF;
    #2;
    do_reset();
    step();
    chk("first_cycle_no_gnt", o_cg, 0);
    c_req = 0;
    step();

    // CPU read of a preloaded word
    c_req = 1; c_wr = 0; c_addr = 32'h10;
    step();
    chk("029_c_gnt", o_cg, 1);
    chk("029_c_rvalid", c_rvalid, 1);
    chk("029_c_rdata", c_rdata, 32'hDEADBEEF);
    c_req = 0;
    step();
    chk("029_rvalid_one", c_rvalid, 0);
    chk("029_rdata_hold", c_rdata, 32'hDEADBEEF);

    // both request: CPU first, debug when CPU drops
    c_req = 1; c_addr = 32'h14;
    d_req = 1; d_wr = 0; d_addr = 32'h10; d_lock = 0;
    step();
    chk("030_c_gnt", o_cg, 1);
    chk("030_d_gnt", o_dg, 0);
    c_req = 0;
    step();
    chk("030_d_gnt_after", o_dg, 1);
    d_req = 0;
    step();

    // locked debug burst of six wanted beats, MAX_BURST caps it at four
    d_req = 1; d_wr = 1; d_lock = 1; d_addr = 32'h30; d_wdata = 32'hA5A5;
    step();
    chk("031_beat1", o_dg, 1);
    c_req = 1; c_wr = 0; c_addr = 32'h30;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk($sformatf("031_beat%0d", i), o_dg, 1);
    end
    step();
    chk("031_cpu_after_d", o_dg, 0);
    chk("031_cpu_after_c", o_cg, 1);
    c_req = 0;
    n = 0;
    for (int i = 0; i < 4 && n < 2; i++) begin
      step();
      if (g_d) n++;
    end
    d_req = 0; d_lock = 0;
    step();

    // CPU write, then debug read-back
    c_req = 1; c_wr = 1; c_addr = 32'h20; c_wdata = 32'h12345678;
    step();
    chk("034_mem_wr", o_mw, 1);
    c_req = 0;
    d_req = 1; d_wr = 0; d_addr = 32'h20;
    step();
    chk("034_mem_wr_off", o_mw, 0);
    chk("034_d_rvalid", d_rvalid, 1);
    chk("034_d_rdata", d_rdata, 32'h12345678);
    d_req = 0;
    step();

    // continuous contention: aging lets debug in on the ninth cycle
    c_req = 1; c_wr = 0; c_addr = 32'h10;
    d_req = 1; d_wr = 0; d_addr = 32'h20;
    for (int i = 1; i <= 10; i++) begin
      step();
`ifdef MEM_ARB_AGING_EN
      chk($sformatf("032_d_cyc%0d", i), o_dg, (i == 9) ? 1 : 0);
`else
      chk($sformatf("032_d_cyc%0d", i), o_dg, 0);
`endif
    end
    c_req = 0; d_req = 0;
    step();

    // reset right after a granted debug read swallows the data
    d_req = 1; d_wr = 0; d_addr = 32'h10;
    step();
    chk("033_d_gnt", o_dg, 1);
    do_reset();
    chk("033_d_rvalid_after", d_rvalid, 0);
    step();
    chk("033_no_gnt_first", o_cg, 0);
    step();
    chk("033_gnt_second", o_cg, 1);
    c_req = 0;
    step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (g_c || !c_req) begin
        if ($urandom_range(3) != 0) begin
          c_req = 1;
          c_wr = 1'($urandom_range(1));
          c_addr = 32'($urandom_range(15)) << 2;
          c_wdata = $urandom;
        end else c_req = 0;
      end
      if (g_d || !d_req) begin
        if ($urandom_range(2) != 0) begin
          d_req = 1;
          d_wr = 1'($urandom_range(1));
          d_lock = ($urandom_range(2) == 0);
          d_addr = 32'($urandom_range(15)) << 2;
          d_wdata = $urandom;
        end else begin
          d_req = 0;
          d_lock = 0;
        end
      end
      step();
    end

    c_req = 0; d_req = 0; d_lock = 0;
    repeat (3) step();
    chk("c_reads_drained", cq.size(), 0);
    chk("d_reads_drained", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
